// File: rtl/irq_encoder_16_to_4_pkg.sv
// Shared types and constants for the 16-line interrupt encoder.
// Holds the offer FSM state enum and the one-hot clear helper.
package irq_encoder_16_to_4_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_encoder_16_to_4_if.sv
// Request/offer bundle of the encoder; slave is the encoder, master is the
// requester/consumer side that drives lines, enables and out_ready.
interface irq_encoder_16_to_4_if;
  import irq_encoder_16_to_4_pkg::*;

  logic             ena;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] mask;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out;
  logic [N_REQ-1:0] pending;
  logic             dropped;

  modport master (
    output ena, req, mask, out_ready,
    input  out_valid, out, pending, dropped
  );

  modport slave (
    input  ena, req, mask, out_ready,
    output out_valid, out, pending, dropped
  );

endinterface

// File: rtl/irq_encoder_16_to_4_prio.sv
// Fixed-priority encoder, lowest set bit wins (bit 0 highest); purely
// combinational, idx is 0 when no bit is set.
module priority_encoder_16_to_4
  import irq_encoder_16_to_4_pkg::*;
(
  input  logic [N_REQ-1:0] in,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the last hit, the lowest index, is what sticks.
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (in[i]) idx = IDX_W'(i);
    end
  end

  assign any = |in;

endmodule

// File: rtl/irq_encoder_16_to_4.sv
// Sticky 16-line IRQ capture with fixed-priority valid/ready offer of the
// winning index; offer appears one edge after capture, held until accepted.
module irq_encoder_16_to_4
  import irq_encoder_16_to_4_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  irq_encoder_16_to_4_if.slave  bus
);

  state_t           state;
  logic             vld_q;
  logic [IDX_W-1:0] out_q;
  logic [N_REQ-1:0] pend_q;
  logic             drop_q;

  logic [N_REQ-1:0] setv;
  logic             fire;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] pend_nxt;
  logic [N_REQ-1:0] cand_idle;
  logic [N_REQ-1:0] cand_fire;
  logic [IDX_W-1:0] idle_idx;
  logic [IDX_W-1:0] fire_idx;
  logic             idle_any;
  logic             fire_any;

  assign setv      = bus.req & bus.mask;
  assign fire      = vld_q & bus.out_ready;
  assign clr       = fire ? idx_onehot(out_q) : '0;
  // Set is OR'd in after the clear so a same-edge request survives the fire.
  assign pend_nxt  = setv | (pend_q & ~clr);
  assign cand_idle = pend_q & bus.mask;
  assign cand_fire = cand_idle & ~clr;

  priority_encoder_16_to_4 u_prio_idle (
    .in  (cand_idle),
    .idx (idle_idx),
    .any (idle_any)
  );

  priority_encoder_16_to_4 u_prio_fire (
    .in  (cand_fire),
    .idx (fire_idx),
    .any (fire_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      vld_q  <= 1'b0;
      out_q  <= '0;
      pend_q <= '0;
      drop_q <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      drop_q <= |(setv & pend_q & ~clr);
      case (state)
        IDLE: begin
          if (bus.ena && idle_any) begin
            state <= OFFER;
            vld_q <= 1'b1;
            out_q <= idle_idx;
          end
        end
        OFFER: begin
          // Without a fire the offer is frozen: no withdrawal, no re-pick.
          if (fire) begin
            if (bus.ena && fire_any) begin
              out_q <= fire_idx;
            end else begin
              state <= IDLE;
              vld_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out       = out_q;
  assign bus.pending   = pend_q;
  assign bus.dropped   = drop_q;

endmodule

// File: tb/tb_irq_encoder_16_to_4.sv
// Randomized and directed bench for irq_encoder_16_to_4 against a
// behavioural model of the pending set and the offer.
module tb_irq_encoder_16_to_4;

  logic clk;
  logic rst;
  logic cmp_en;
  int   n_chk;
  int   n_pass;

  irq_encoder_16_to_4_if bus ();

  irq_encoder_16_to_4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: whether an index is on offer, which one, the pending set, drop pulse.
  logic        m_vld;
  logic [3:0]  m_out;
  logic [15:0] m_pend;
  logic        m_drop;

  function automatic logic [3:0] lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  // Returns {vld, out, pending, dropped} after one edge.
  function automatic logic [21:0] model_next(
    input logic vld, input logic [3:0] o, input logic [15:0] p,
    input logic ena, input logic [15:0] req, input logic [15:0] mask,
    input logic rdy);
    logic        fired;
    logic        drop;
    logic [15:0] np;
    logic [15:0] cand;
    logic        nv;
    logic [3:0]  no;
    fired = vld && rdy;
    np    = p;
    cand  = p & mask;
    if (fired) begin
      np[o]   = 1'b0;
      cand[o] = 1'b0;
    end
    drop = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (req[i] && mask[i]) begin
        if (np[i]) drop = 1'b1;
        np[i] = 1'b1;
      end
    end
    nv = vld;
    no = o;
    if (!(vld && !fired)) begin
      if (ena && cand != 16'h0) begin
        nv = 1'b1;
        no = lowest(cand);
      end else begin
        nv = 1'b0;
      end
    end
    return {nv, no, np, drop};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_vld  <= 1'b0;
      m_out  <= 4'd0;
      m_pend <= 16'h0;
      m_drop <= 1'b0;
    end else begin
      {m_vld, m_out, m_pend, m_drop} <= model_next(m_vld, m_out, m_pend,
          bus.ena, bus.req, bus.mask, bus.out_ready);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_out_valid", 32'(bus.out_valid), 32'(m_vld));
      check("cmp_out",       32'(bus.out),       32'(m_out));
      check("cmp_pending",   32'(bus.pending),   32'(m_pend));
      check("cmp_dropped",   32'(bus.dropped),   32'(m_drop));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    cmp_en = 1'b0;
    n_chk = 0;
    n_pass = 0;
    bus.ena = 1'b0;
    bus.req = 16'h0;
    bus.mask = 16'hFFFF;
    bus.out_ready = 1'b0;

    @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out",       32'(bus.out),       32'd0);
    check("reset_pending",   32'(bus.pending),   32'd0);
    check("reset_dropped",   32'(bus.dropped),   32'd0);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Single request on line 5.
    bus.ena = 1'b1;
    bus.req = 16'h0020;
    step(1);
    bus.req = 16'h0;
    check("single_pend",  32'(bus.pending),   32'h0020);
    check("single_vld0",  32'(bus.out_valid), 32'd0);
    step(1);
    check("single_vld1",  32'(bus.out_valid), 32'd1);
    check("single_out",   32'(bus.out),       32'd5);
    bus.out_ready = 1'b1;
    step(1);
    check("single_clear", 32'(bus.pending),   32'h0);
    check("single_idle",  32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Priority and back-to-back from pending 8009.
    bus.ena = 1'b0;
    bus.req = 16'h8009;
    step(1);
    bus.req = 16'h0;
    bus.ena = 1'b1;
    bus.out_ready = 1'b1;
    step(1);
    check("b2b_out0", 32'(bus.out), 32'd0);
    check("b2b_vld0", 32'(bus.out_valid), 32'd1);
    step(1);
    check("b2b_out3", 32'(bus.out), 32'd3);
    step(1);
    check("b2b_out15", 32'(bus.out), 32'd15);
    step(1);
    check("b2b_end_vld", 32'(bus.out_valid), 32'd0);
    check("b2b_end_pend", 32'(bus.pending), 32'h0);
    bus.out_ready = 1'b0;

    // Stall: offer of 2 must not be withdrawn by mask/ena dropping.
    bus.req = 16'h0004;
    step(1);
    bus.req = 16'h0;
    step(1);
    check("stall_out", 32'(bus.out), 32'd2);
    bus.mask = 16'h0;
    bus.ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("stall_hold_vld", 32'(bus.out_valid), 32'd1);
      check("stall_hold_out", 32'(bus.out), 32'd2);
    end
    bus.mask = 16'hFFFF;
    bus.ena = 1'b1;
    bus.out_ready = 1'b1;
    step(1);
    check("stall_drain", 32'(bus.pending), 32'h0);
    bus.out_ready = 1'b0;

    // Set beats clear, then drop pulse.
    bus.req = 16'h0010;
    step(1);
    bus.req = 16'h0;
    step(1);
    check("sbc_out", 32'(bus.out), 32'd4);
    bus.out_ready = 1'b1;
    bus.req = 16'h0010;
    step(1);
    check("sbc_pend", 32'(bus.pending), 32'h0010);
    check("sbc_nodrop", 32'(bus.dropped), 32'd0);
    check("sbc_idle", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    bus.ena = 1'b0;
    step(1);
    bus.req = 16'h0;
    check("drop_pulse", 32'(bus.dropped), 32'd1);
    step(1);
    check("drop_end", 32'(bus.dropped), 32'd0);
    bus.ena = 1'b1;
    bus.out_ready = 1'b1;
    step(2);
    bus.out_ready = 1'b0;

    // ena gating.
    bus.ena = 1'b0;
    bus.req = 16'h0100;
    step(1);
    bus.req = 16'h0;
    check("ena_pend", 32'(bus.pending), 32'h0100);
    step(1);
    check("ena_blocked", 32'(bus.out_valid), 32'd0);
    bus.ena = 1'b1;
    step(1);
    check("ena_vld", 32'(bus.out_valid), 32'd1);
    check("ena_out", 32'(bus.out), 32'd8);
    bus.ena = 1'b0;
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;

    // Async reset mid-offer with pending 00F0, then first capture after release.
    bus.req = 16'h00F0;
    step(1);
    bus.req = 16'h0;
    bus.ena = 1'b1;
    step(1);
    check("rst_pre_vld", 32'(bus.out_valid), 32'd1);
    check("rst_pre_pend", 32'(bus.pending), 32'h00F0);
    #3 rst = 1'b0;
    #1;
    check("rst_async_vld",  32'(bus.out_valid), 32'd0);
    check("rst_async_out",  32'(bus.out),       32'd0);
    check("rst_async_pend", 32'(bus.pending),   32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus.ena = 1'b0;
    bus.req = 16'h0001;
    step(1);
    bus.req = 16'h0;
    check("rst_first_cap", 32'(bus.pending), 32'h0001);
    check("rst_first_vld", 32'(bus.out_valid), 32'd0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      bus.req       = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom) : 16'h0;
      bus.mask      = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'hFFFF;
      bus.ena       = ($urandom_range(0, 4) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
      step(1);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/irq_encoder_16_to_4.md
IRQ_ENCODER_16_TO_4 -- requirements
Module: irq_encoder_16_to_4

Interface
REQ-001 The block SHALL have no parameters: widths fixed at 16 request lines, 4-bit index.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low.
REQ-004 ena  input  1  offer enable; low blocks new offers, does not block capture.
REQ-005 req  input  16  request lines, sampled every rising edge.
REQ-006 mask  input  16  per-line enable; 1 = line eligible for capture and offer.
REQ-007 out_ready  input  1  consumer accepts the offered index.
REQ-008 out_valid  output  1  registered; an index is offered.
REQ-009 out  output  4  registered; offered index.
REQ-010 pending  output  16  registered sticky pending vector.
REQ-011 dropped  output  1  registered one-cycle pulse; a request hit an already-pending line.

Function
REQ-012 Capture: each edge, pending[i] SHALL become 1 if req[i]&mask[i], else 0 if line i is cleared this edge, else hold.
REQ-013 Set SHALL win over clear when req[i]&mask[i] coincides with the handshake clearing line i.
REQ-014 Handshake (fire) SHALL be out_valid&out_ready; fire clears pending[out] at that edge.
REQ-015 Priority SHALL be fixed: lowest set index of the candidate vector wins (index 0 highest).
REQ-016 FSM states SHALL be IDLE (out_valid=0) and OFFER (out_valid=1).
REQ-017 IDLE -> OFFER when ena=1 and (pending&mask)!=0; out loads the winner at that edge.
REQ-018 OFFER with no fire SHALL hold out and out_valid stable regardless of ena, mask, req changes (no withdrawal).
REQ-019 OFFER with fire: candidate = pending&mask with bit out cleared; if ena=1 and candidate!=0, stay OFFER and load its winner (back-to-back, one index per cycle); else -> IDLE.
REQ-020 Requests captured at the fire edge SHALL not join that edge's candidate; they are eligible from the next edge.
REQ-021 Latency: req asserted before edge E0 with block IDLE and ena=1 SHALL give out_valid=1 after edge E1.
REQ-022 dropped SHALL pulse for one cycle when any req[i]&mask[i] arrives while pending[i]=1 and line i is not cleared that edge; the request is merged, not queued.
REQ-023 out SHALL be 0 whenever out_valid=0 is entered from reset; otherwise out holds its last value in IDLE.
REQ-024 mask=0 on a line SHALL neither capture it nor offer it, but SHALL not clear an existing pending bit.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, out_valid=0, out=0, pending=0, dropped=0, independent of clk.
REQ-026 Reset mid-OFFER SHALL abandon the offer; no fire is recorded.
REQ-027 After rst deasserts, first capture SHALL occur at the first following rising edge.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, OFFER) and constants N_REQ=16, IDX_W=4.
REQ-029 One combinational sub-module priority_encoder_16_to_4 (in[15:0] -> idx[3:0], any) SHALL be used for winner selection, instantiated for both the IDLE and post-fire candidate vectors.
REQ-030 Clear one-hot SHALL be generated internally from out gated by fire.

Verification
REQ-031 Reset: rst=0 mid-OFFER with pending=16'h00F0 -> out_valid=0, out=0, pending=0 same cycle, before next edge.
REQ-032 Single request: mask=16'hFFFF, ena=1, req=16'h0020 for one cycle -> out_valid=1, out=5 after second edge; out_ready=1 -> pending=0, back to IDLE.
REQ-033 Priority/back-to-back: pending=16'h8009, out_ready held 1 -> out sequence 0,3,15 on consecutive cycles, then out_valid=0.
REQ-034 Stall/no withdrawal: offer out=2, out_ready=0, then mask=0 and ena=0 for 5 cycles -> out_valid=1, out=2 held throughout.
REQ-035 Set-beats-clear and drop: fire on out=4 while req=16'h0010 -> pending[4]=1 after edge, no dropped; repeat req[4] while pending[4]=1, no fire -> dropped pulses exactly one cycle.
REQ-036 ena gating: ena=0, req=16'h0100 -> pending=16'h0100, out_valid=0; raise ena -> out_valid=1, out=8 one edge later.
